autoencoder_sequencer: RTL
==========================

AUTOENCODER_SEQUENCER -- requirements
Module: autoencoder_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: `clock` is the single clock and `reset` is the asynchronous active-high reset.
REQ-002 Ports SHALL be:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous active-high reset
- `start`  in  1  single-cycle pulse; begins program at address 0
- `hold`  in  1  freezes all state while high
- `loop_count`  in  8  repeat count, sampled on accepted start
- `instr_in`  in  16  instruction memory read data; valid the cycle after `pc` is driven
- `pc`  out  16  instruction address
- `write_enable_mem`  out  1  data memory write strobe
- `enable_ALU`  out  1  ALU enable
- `enable_sel_mem`  out  1  sector-selector capture strobe
- `dest_control`  out  2  writeback source: 00 ALU, 01 sigmoid, 10 ReLu, 11 sigmoid-diff
- `op_select`  out  2  ALU op: 00 add, 01 sub, 10 mul
- `operand2_sel`  out  1  0 = memory operand, 1 = constant zero
- `busy`  out  1  program running
- `done`  out  1  HALT reached
- `illegal`  out  1  sticky; undefined opcode seen
- `ir`  out  16  latched current instruction

Function
REQ-003 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, WB and DONE.
REQ-004 IDLE SHALL go to FETCH on `start`, with `pc` set to 0, `loop_cnt` loaded from `loop_count`, and `illegal` cleared.
REQ-005 FETCH SHALL drive `pc` and go to DECODE on the next edge.
REQ-006 DECODE SHALL latch `instr_in` into `ir` at the DECODE-to-next edge.
REQ-007 Opcode `ir[15:12]` SHALL be decoded as follows (each entry: op_select / operand2_sel / dest_control):
- 0x1 ADD: 00 / 0 / 00
- 0x2 SUB: 01 / 0 / 00
- 0x3 MUL: 10 / 0 / 00
- 0x4 MOV: 00 / 1 / 00
- 0x5 SIGM: 00 / 1 / 01
- 0x6 RELU: 00 / 1 / 10
- 0x7 DSIG: 00 / 1 / 11
REQ-008 For opcodes 0x1-0x7, the sequence SHALL be DECODE -> EXEC -> WB -> FETCH, with `pc` = `pc`+1 on WB exit; each such instruction takes exactly 4 cycles.
REQ-009 `enable_sel_mem` SHALL be 1 only in EXEC; `enable_ALU` SHALL be 1 in EXEC and WB; `write_enable_mem` SHALL be 1 only in WB.
REQ-010 `op_select`, `operand2_sel` and `dest_control` SHALL be held from the decoded `ir` throughout EXEC and WB, and SHALL be 0 elsewhere.
REQ-011 Opcode 0x0 NOP SHALL go DECODE -> FETCH with `pc`+1, producing no strobes (2 cycles).
REQ-012 Opcode 0xA LOOP SHALL use target = {8'h00, `ir[11:4]`}:
- if `loop_cnt` != 0: decrement `loop_cnt` and set `pc` = target;
- else: set `pc` = `pc`+1;
- then go to FETCH (2 cycles).
REQ-013 Opcode 0xF HALT SHALL go DECODE -> DONE.
REQ-014 Opcodes 0x8, 0x9, 0xB-0xE SHALL set `illegal`=1 and otherwise behave as NOP.
REQ-015 `pc` arithmetic SHALL be 16-bit modulo: 0xFFFF+1 = 0x0000, and execution continues.
REQ-016 `busy` SHALL be 1 in FETCH, DECODE, EXEC and WB, and 0 otherwise.
REQ-017 `done` SHALL be 1 only in DONE, as a level.
REQ-018 DONE SHALL remain until `start`; `start` in DONE restarts exactly as from IDLE.
REQ-019 `start` SHALL be ignored while `busy`=1.
REQ-020 When `hold`=1, state, `pc`, `ir`, `loop_cnt` and `illegal` SHALL be frozen, and all strobes (`write_enable_mem`, `enable_ALU`, `enable_sel_mem`) SHALL be forced to 0.
REQ-021 `start` SHALL be ignored while `hold`=1.
REQ-022 On release of `hold`, the block SHALL re-enter the frozen state and repeat that state's outputs for one full cycle.
REQ-023 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from input to output.

Reset
REQ-024 Assertion of `reset` SHALL immediately force state to IDLE and force `pc`, `ir`, `loop_cnt`, `op_select`, `dest_control`, `operand2_sel`, all strobes, `busy`, `done` and `illegal` to 0, including mid-instruction (no partial WB completes).
REQ-025 After `reset` deasserts, the block SHALL stay in IDLE until `start`.

Verification
REQ-026 Program [0x1123 ADD, 0xF000]: `start` -> `pc` 0,0,0,0 over FETCH/DECODE/EXEC/WB with `write_enable_mem`=1 only in cycle 4, `op_select`=00 and `dest_control`=00 in EXEC/WB; then `pc`=1, and `done`=1 on cycle 7.
REQ-027 Program [0x6450 RELU, 0x5450 SIGM, 0x7450 DSIG, 0xF000]: `dest_control` SHALL be 10, 01, 11 in the respective WB cycles, with `operand2_sel`=1 in each.
REQ-028 `loop_count`=2, program [0x2123 SUB @0, 0xA000 LOOP->0, 0xF000]: SUB executes 3 times (3 `write_enable_mem` pulses), `loop_cnt` ends at 0, then `done`.
REQ-029 `reset` pulsed during WB of an ADD -> `write_enable_mem` drops the same cycle; all outputs are 0; the block is in IDLE; a later `start` refetches `pc`=0.
REQ-030 `hold` high for 3 cycles during EXEC -> `enable_ALU` and `enable_sel_mem` are 0 and `pc` is frozen; after release, EXEC repeats one cycle, then WB.
REQ-031 Instruction 0xC000 -> `illegal`=1 sticky, `pc` advances by 1; `start` while `busy` has no effect; `start` in DONE clears `illegal` and `done`.

Source files
------------

// File: rtl/autoencoder_sequencer.sv
// autoencoder_sequencer: instruction fetch/decode sequencer driving the ALU, activation and memory strobes
module autoencoder_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        hold,
    input  logic [7:0]  loop_count,
    input  logic [15:0] instr_in,
    output logic [15:0] pc,
    output logic        write_enable_mem,
    output logic        enable_ALU,
    output logic        enable_sel_mem,
    output logic [1:0]  dest_control,
    output logic [1:0]  op_select,
    output logic        operand2_sel,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [15:0] ir
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_DONE} state_t;
    state_t      r_state, w_state;
    logic [15:0] r_pc, w_pc, r_ir, w_ir;
    logic [7:0]  r_cnt, w_cnt;
    logic        r_ill, w_ill, r_held;
    logic        r_we, r_alu, r_sel, r_o2, r_busy, r_done;
    logic [1:0]  r_dest, r_op;
    logic [3:0]  w_op, w_dec;
    logic        w_xw, w_run;
    assign w_dec = instr_in[15:12];
    // r_held makes the first cycle after hold release replay the frozen state
    assign w_run = !hold && !r_held;
    // next-state, pc, ir, loop counter and illegal flag
    always_comb begin
        w_state = r_state;
        w_pc    = r_pc;
        w_ir    = r_ir;
        w_cnt   = r_cnt;
        w_ill   = r_ill;
        if (w_run) begin
            case (r_state)
                S_IDLE, S_DONE: if (start) begin
                    w_state = S_FETCH;
                    w_pc    = 16'h0000;
                    w_cnt   = loop_count;
                    w_ill   = 1'b0;
                end
                S_FETCH: w_state = S_DECODE;
                S_DECODE: begin
                    w_ir = instr_in;
                    if (w_dec >= 4'h1 && w_dec <= 4'h7) w_state = S_EXEC;
                    else if (w_dec == 4'hF) w_state = S_DONE;
                    else begin
                        w_state = S_FETCH;
                        if (w_dec == 4'hA && r_cnt != 8'd0) begin
                            w_cnt = r_cnt - 8'd1;
                            w_pc  = {8'h00, instr_in[11:4]};
                        end else w_pc = r_pc + 16'd1;
                        if (w_dec != 4'h0 && w_dec != 4'hA) w_ill = 1'b1;
                    end
                end
                S_EXEC: w_state = S_WB;
                S_WB: begin
                    w_state = S_FETCH;
                    w_pc    = r_pc + 16'd1;
                end
                default: w_state = S_IDLE;
            endcase
        end
    end
    assign w_op = w_ir[15:12];
    assign w_xw = (w_state == S_EXEC) || (w_state == S_WB);
    // state plus outputs registered from the next state, strobes masked while held
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_cnt   <= '0;
            r_ill   <= 1'b0;
            r_held  <= 1'b0;
            r_we    <= 1'b0;
            r_alu   <= 1'b0;
            r_sel   <= 1'b0;
            r_o2    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dest  <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_state;
            r_pc    <= w_pc;
            r_ir    <= w_ir;
            r_cnt   <= w_cnt;
            r_ill   <= w_ill;
            r_held  <= hold;
            r_we    <= !hold && w_state == S_WB;
            r_alu   <= !hold && w_xw;
            r_sel   <= !hold && w_state == S_EXEC;
            r_o2    <= w_xw && w_op >= 4'h4;
            r_busy  <= w_state inside {S_FETCH, S_DECODE, S_EXEC, S_WB};
            r_done  <= w_state == S_DONE;
            r_dest  <= (w_xw && w_op >= 4'h5) ? w_op[1:0] : 2'b00;
            r_op    <= !w_xw ? 2'b00 : w_op == 4'h2 ? 2'b01 : w_op == 4'h3 ? 2'b10 : 2'b00;
        end
    end
    assign pc               = r_pc;
    assign ir               = r_ir;
    assign illegal          = r_ill;
    assign write_enable_mem = r_we;
    assign enable_ALU       = r_alu;
    assign enable_sel_mem   = r_sel;
    assign operand2_sel     = r_o2;
    assign busy             = r_busy;
    assign done             = r_done;
    assign dest_control     = r_dest;
    assign op_select        = r_op;
endmodule
